// File: rtl/g_serial_sub32_if.sv
// Bus bundle for the serial subtractor: request operands, start/busy/done
// handshake and the registered result with its flags.
interface g_serial_sub32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BI;
    logic [WIDTH-1:0] Diff;
    logic             BO;
    logic             OF;
    logic             ZF;
    logic             busy;
    logic             done;

    // Requester side: drives operands and start, observes result.
    modport master (
        output start, A, B, BI,
        input  Diff, BO, OF, ZF, busy, done
    );

    // Subtractor side.
    modport slave (
        input  start, A, B, BI,
        output Diff, BO, OF, ZF, busy, done
    );
endinterface

// File: rtl/g_serial_sub32.sv
// Multi-cycle subtractor: A - B - BI computed as A + ~B + ~BI, one SLICE-bit
// slice per clock, LSB slice first. The carry between slices lives in a
// register; flags are captured when the last slice retires.
module g_serial_sub32 #(
    parameter int WIDTH = 32,
    parameter int SLICE = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    g_serial_sub32_if.slave      bus
);
    localparam int NSLICE = (WIDTH + SLICE - 1) / SLICE;
    localparam int PADW   = NSLICE * SLICE;
    localparam int LAST_W = WIDTH - (NSLICE - 1) * SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // The top slice may be narrower than SLICE; this mask keeps its unused
    // upper bits at zero so the carry lands exactly at bit LAST_W.
    localparam logic [SLICE-1:0] LAST_MASK = SLICE'((1 << LAST_W) - 1);
    localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_finish;

    // Operands are zero-extended to a whole number of slices.
    logic [PADW-1:0]   r_a;
    logic [PADW-1:0]   r_b;
    logic [PADW-1:0]   r_diff;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic              r_bo;
    logic              r_of;
    logic              r_zf;

    logic              w_last;
    logic [SLICE-1:0]  w_mask;
    logic [SLICE-1:0]  w_a_s;
    logic [SLICE-1:0]  w_b_inv;
    logic [SLICE:0]    w_sum;
    logic [SLICE-1:0]  w_sum_bits;
    logic              w_cout;
    logic [PADW-1:0]   w_diff_nxt;
    logic              w_of_nxt;
    logic              w_zf_nxt;

    // ------------------------------------------------------------------
    // Slice datapath
    // ------------------------------------------------------------------
    assign w_last     = (r_idx == LAST_IDX);
    assign w_mask     = w_last ? LAST_MASK : {SLICE{1'b1}};
    assign w_a_s      = r_a[r_idx*SLICE +: SLICE];
    assign w_b_inv    = ~r_b[r_idx*SLICE +: SLICE] & w_mask;
    assign w_sum      = {1'b0, w_a_s} + {1'b0, w_b_inv} + {{SLICE{1'b0}}, r_carry};
    assign w_sum_bits = w_sum[SLICE-1:0] & w_mask;
    // Carry out of the real MSB of this slice.
    assign w_cout     = w_last ? w_sum[LAST_W] : w_sum[SLICE];

    // Difference with the current slice merged in; on the last slice this
    // is the complete result used for the flags.
    always_comb begin
        w_diff_nxt = r_diff;
        w_diff_nxt[r_idx*SLICE +: SLICE] = w_sum_bits;
    end

    // Signed overflow: operand signs differ and result sign differs from A.
    assign w_of_nxt = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                      (w_diff_nxt[WIDTH-1] != r_a[WIDTH-1]);
    // Padding bits are always zero, so testing the whole vector is the same
    // as testing the WIDTH-bit result.
    assign w_zf_nxt = (w_diff_nxt == '0);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state; start is only honoured in IDLE and DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, per-slice writeback and flag capture on the last slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_diff  <= '0;
            r_carry <= 1'b1;
            r_idx   <= '0;
            r_bo    <= 1'b0;
            r_of    <= 1'b0;
            r_zf    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= PADW'(bus.A);
            r_b     <= PADW'(bus.B);
            r_carry <= ~bus.BI;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_diff  <= w_diff_nxt;
            r_carry <= w_cout;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            if (w_finish) begin
                r_bo <= ~w_cout;
                r_of <= w_of_nxt;
                r_zf <= w_zf_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.Diff = r_diff[WIDTH-1:0];
    assign bus.BO   = r_bo;
    assign bus.OF   = r_of;
    assign bus.ZF   = r_zf;
    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);

endmodule

// File: tb/tb_g_serial_sub32.sv
// Scoreboard bench for g_serial_sub32: expected results are queued when a
// start is driven and compared whenever done pulses.
module tb_g_serial_sub32;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   cyc;
    int   done_cnt;

    typedef struct {
        logic [31:0] diff;
        logic        bo;
        logic        of_;
        logic        zf;
    } exp_t;

    exp_t sb[$];
    int   done_times[$];

    g_serial_sub32_if #(.WIDTH(32)) bus ();

    g_serial_sub32 #(.WIDTH(32), .SLICE(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bi);
        exp_t        e;
        logic [32:0] full;
        full   = {1'b0, a} - {1'b0, b} - {32'b0, bi};
        e.diff = full[31:0];
        e.bo   = full[32];
        e.of_  = (a[31] != b[31]) && (e.diff[31] != a[31]);
        e.zf   = (e.diff == 32'h0);
        return e;
    endfunction

    // Result monitor: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            exp_t e;
            done_cnt++;
            done_times.push_back(cyc);
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("diff", bus.Diff, e.diff);
                chk("bo",   {31'b0, bus.BO}, {31'b0, e.bo});
                chk("of",   {31'b0, bus.OF}, {31'b0, e.of_});
                chk("zf",   {31'b0, bus.ZF}, {31'b0, e.zf});
                chk("busy_in_done", {31'b0, bus.busy}, 32'd0);
            end
        end
    end

    // One operation; optional extra start pulses while busy, operands are
    // scrambled after acceptance to show they are registered.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                          input bit glitch);
        int busy_n;
        int d0;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.BI = bi; bus.start = 1'b1;
        sb.push_back(model(a, b, bi));
        d0 = done_cnt;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.A = ~a; bus.B = $urandom; bus.BI = ~bi;
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (done_cnt != d0) break;
            if (bus.busy) busy_n++;
            if (glitch && (i == 1 || i == 3)) begin
                bus.start = 1'b1; bus.A = $urandom; bus.B = $urandom;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("done_seen", done_cnt - d0, 1);
        chk("busy_cycles", busy_n, 7);
        repeat (3) @(negedge clk);
        #1;
        chk("single_done", done_cnt - d0, 1);
        chk("idle_after", {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        int   d0;
        exp_t e;
        n_chk = 0; n_err = 0; cyc = 0; done_cnt = 0;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.BI = 1'b0;
        rst = 1'b1;
        // start together with reset must be dropped
        bus.start = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        chk("rst_diff", bus.Diff, 32'h0);
        chk("rst_flags", {28'b0, bus.BO, bus.OF, bus.ZF, bus.busy}, 32'h0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);

        run_op(32'h0000000A, 32'h00000003, 1'b0, 1'b0);
        run_op(32'h00000000, 32'h00000001, 1'b0, 1'b0);
        run_op(32'h80000000, 32'h00000001, 1'b0, 1'b0);
        run_op(32'h12345678, 32'h12345677, 1'b1, 1'b0);
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        // starts while busy must be ignored
        run_op(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1);

        // reset in the middle of RUN
        @(negedge clk);
        bus.A = 32'h55555555; bus.B = 32'h11111111; bus.BI = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        chk("mid_rst_diff", bus.Diff, 32'h0);
        chk("mid_rst_flags", {28'b0, bus.BO, bus.OF, bus.ZF, bus.busy}, 32'h0);
        repeat (10) @(negedge clk);
        #1;
        chk("mid_rst_no_done", done_cnt - d0, 0);
        run_op(32'h00001000, 32'h00000FFF, 1'b0, 1'b0);

        // start held high: back-to-back results every 8 cycles
        e = model(32'h00000005, 32'h00000009, 1'b1);
        repeat (3) sb.push_back(e);
        @(negedge clk);
        bus.A = 32'h00000005; bus.B = 32'h00000009; bus.BI = 1'b1; bus.start = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (done_cnt == d0 + 3) break;
            if (done_cnt > d0 && bus.busy && i % 4 == 0) begin
                chk("held_diff_bo", {31'b0, bus.BO}, {31'b0, e.bo});
                chk("held_zf", {31'b0, bus.ZF}, {31'b0, e.zf});
            end
        end
        bus.start = 1'b0;
        chk("held_done_cnt", done_cnt - d0, 3);
        if (done_times.size() >= 3) begin
            int n;
            n = done_times.size();
            chk("gap1", done_times[n-2] - done_times[n-3], 8);
            chk("gap2", done_times[n-1] - done_times[n-2], 8);
        end
        repeat (4) @(negedge clk);
        #1;
        chk("held_stopped", done_cnt - d0, 3);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
